// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants, FSM state type and channel helper for sobel_stream
//
// Purpose : common definitions imported by the Sobel edge detector files.
// Contents: LATENCY   - input-accept edge to out_valid edge distance, in clocks
//           MODE_MAG  - mode value selecting saturated |Gx|+|Gy| output
//           MODE_THR  - mode value selecting binary threshold output
//           state_t   - frame FSM state
//           ch_slice  - extracts channel idx of a packed pixel (up to 64 bits wide)

package sobel_pkg;

   localparam int   LATENCY  = 2;
   localparam logic MODE_MAG = 1'b0;
   localparam logic MODE_THR = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Callers zero-extend the pixel to 64 bits and cast the result down to CH_W.
   function automatic logic [15:0] ch_slice(input logic [63:0] pix,
                                            input int          idx,
                                            input int          ch_w);
      return 16'(pix >> (idx * ch_w));
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - one-line pixel buffer, shared read/write address, read-before-write
//
// Purpose: holds one image line. The read is combinational, so the old
//          contents at addr are visible in the same cycle that a new value
//          is written there on the clock edge.
// Ports  : clk     - clock
//          wr_en   - write strobe
//          addr    - column address for both ports
//          wr_data - pixel written at addr on the rising edge
//          rd_data - pixel currently stored at addr
// The storage has no reset.

module sobel_line_buf #(
   parameter  int DEPTH = 640,
   parameter  int WIDTH = 12,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with border masking
//
// Purpose: accepts raster-order pixels and emits one edge pixel per accepted
//          pixel, two clocks later. Each output is the result for the window
//          centred IMG_W+1 pixels earlier in raster order.
// Ports  : clk       - clock, rising edge
//          rst_n     - asynchronous active-low reset
//          in_valid  - input pixel strobe (no backpressure)
//          in_sof    - with in_valid, marks raster pixel (0,0)
//          in_pixel  - N_CH channels of CH_W bits, channel 0 in the LSBs
//          mode      - 0 magnitude, 1 binary threshold
//          thresh    - threshold applied to every channel in mode 1
//          out_valid - one pulse per accepted input pixel
//          out_sof   - with out_valid, marks the result for centre (0,0)
//          out_pixel - edge result, same packing as in_pixel

module sobel_stream
   import sobel_pkg::*;
#(
   parameter  int CH_W  = 4,
   parameter  int N_CH  = 3,
   parameter  int IMG_W = 640,
   parameter  int IMG_H = 480,
   localparam int PIX_W = CH_W * N_CH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             mode,
   input  logic [CH_W-1:0]  thresh,
   output logic             out_valid,
   output logic             out_sof,
   output logic [PIX_W-1:0] out_pixel
);

   localparam int              XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int              YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int              SW     = CH_W + 2;
   localparam logic [CH_W-1:0] CH_MAX = '1;

   state_t           state, state_nxt;
   logic [XW-1:0]    col, col_nxt, x;
   logic [YW-1:0]    row, row_nxt, y;
   logic             accept, last;

   // Frame control: in_sof overrides the counters so a resync pixel is (0,0).
   assign accept = in_valid & (in_sof | (state == ST_RUN));
   assign x      = in_sof ? '0 : col;
   assign y      = in_sof ? '0 : row;
   assign last   = (int'(x) == IMG_W - 1) && (int'(y) == IMG_H - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      if (accept) begin
         if (last && !in_sof) begin
            state_nxt = ST_IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
         end else begin
            state_nxt = ST_RUN;
            if (int'(x) == IMG_W - 1) begin
               col_nxt = '0;
               row_nxt = y + 1'b1;
            end else begin
               col_nxt = x + 1'b1;
               row_nxt = y;
            end
         end
      end
   end

   // Line buffers: up1 is row y-1, up2 is row y-2 at column x.
   logic [PIX_W-1:0] up1, up2;

   sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_prev1 (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (x),
      .wr_data (in_pixel),
      .rd_data (up1)
   );

   sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_prev2 (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (x),
      .wr_data (up1),
      .rd_data (up2)
   );

   // Window: column a is x-2 (left), b is x-1 (centre); the incoming column
   // {up2, up1, in_pixel} is the right column and is used before registering.
   logic [PIX_W-1:0] a_top, a_mid, a_bot, b_top, b_mid, b_bot;

   always_ff @(posedge clk) begin
      if (accept) begin
         a_top <= b_top;
         a_mid <= b_mid;
         a_bot <= b_bot;
         b_top <= up2;
         b_mid <= up1;
         b_bot <= in_pixel;
      end
   end

   logic [N_CH-1:0][SW-1:0] sum_l, sum_r, sum_u, sum_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_sum
      logic [CH_W-1:0] at, am, ab, bt, bb, ct, cm, cb;
      assign at = CH_W'(ch_slice(64'(a_top), i, CH_W));
      assign am = CH_W'(ch_slice(64'(a_mid), i, CH_W));
      assign ab = CH_W'(ch_slice(64'(a_bot), i, CH_W));
      assign bt = CH_W'(ch_slice(64'(b_top), i, CH_W));
      assign bb = CH_W'(ch_slice(64'(b_bot), i, CH_W));
      assign ct = CH_W'(ch_slice(64'(up2), i, CH_W));
      assign cm = CH_W'(ch_slice(64'(up1), i, CH_W));
      assign cb = CH_W'(ch_slice(64'(in_pixel), i, CH_W));
      // 1-2-1 weighted sums; the doubled term is a one-bit left shift.
      assign sum_l[i] = SW'(at) + {1'b0, am, 1'b0} + SW'(ab);
      assign sum_r[i] = SW'(ct) + {1'b0, cm, 1'b0} + SW'(cb);
      assign sum_u[i] = SW'(at) + {1'b0, bt, 1'b0} + SW'(ct);
      assign sum_d[i] = SW'(ab) + {1'b0, bb, 1'b0} + SW'(cb);
   end

   // Stage 1 registers
   logic [N_CH-1:0][SW-1:0] s1_l, s1_r, s1_u, s1_d;
   logic                    s1_valid, s1_sof, s1_zero, s1_mode;
   logic [CH_W-1:0]         s1_thresh;

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_l <= sum_l;
         s1_r <= sum_r;
         s1_u <= sum_u;
         s1_d <= sum_d;
      end
   end

   // Centre is (x-1, y-1); for x=0 it is the last column of an earlier row.
   // x<2 or y<2 therefore covers c<0 and every border centre that can occur.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sof    <= 1'b0;
         s1_zero   <= 1'b0;
         s1_mode   <= MODE_MAG;
         s1_thresh <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sof    <= (int'(x) == 1) && (int'(y) == 1);
            s1_zero   <= (int'(x) < 2) || (int'(y) < 2);
            s1_mode   <= mode;
            s1_thresh <= thresh;
         end
      end
   end

   // Stage 2: absolute differences, saturation, threshold, border mask.
   logic [PIX_W-1:0] res;

   for (genvar i = 0; i < N_CH; i++) begin : g_mag
      logic [SW-1:0]   gx, gy;
      logic [SW:0]     g_sum;
      logic            sat;
      logic [CH_W-1:0] mag, thr;
      assign gx    = (s1_l[i] >= s1_r[i]) ? s1_l[i] - s1_r[i] : s1_r[i] - s1_l[i];
      assign gy    = (s1_u[i] >= s1_d[i]) ? s1_u[i] - s1_d[i] : s1_d[i] - s1_u[i];
      assign g_sum = {1'b0, gx} + {1'b0, gy};
      assign sat   = (gx > SW'(CH_MAX)) || (gy > SW'(CH_MAX)) || (g_sum > (SW+1)'(CH_MAX));
      assign mag   = sat ? '1 : g_sum[CH_W-1:0];
      assign thr   = (mag >= s1_thresh) ? '1 : '0;
      assign res[i*CH_W +: CH_W] = s1_zero ? '0 : ((s1_mode == MODE_MAG) ? mag : thr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_pixel <= '0;
      end else begin
         out_valid <= s1_valid;
         out_sof   <= s1_valid & s1_sof;
         out_pixel <= s1_valid ? res : '0;
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - self-checking bench for sobel_stream on an 8x6 image
//
// Purpose: drives directed frames through sobel_stream and compares every
//          output against a reference Sobel model via a scoreboard queue.
// Ports  : none (top-level bench)

module tb_sobel_stream;
   import sobel_pkg::*;

   localparam int W = 8;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_sof, mode;
   logic [11:0] in_pixel;
   logic [3:0]  thresh;
   logic        out_valid, out_sof;
   logic [11:0] out_pixel;

   sobel_stream #(.CH_W(4), .N_CH(3), .IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .mode      (mode),
      .thresh    (thresh),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_pixel (out_pixel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] pix;
      logic        sof;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb [$];
   exp_t        e_mon;
   logic [11:0] img [W*H];
   logic [31:0] cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          n_out = 0;
   int          base;
   bit          m_run = 0;
   int          m_k = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_out(input int k, input logic md, input logic [3:0] th);
      int          c, cx, cy, l, r, u, d, gx, gy, m;
      int          p [3][3];
      logic [11:0] res;
      logic [11:0] px;
      res = '0;
      c = k - (W + 1);
      if (c < 0) return '0;
      cx = c % W;
      cy = c / W;
      if (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1) return '0;
      for (int ch = 0; ch < 3; ch++) begin
         for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
               px = img[(cy + dy - 1) * W + cx + dx - 1];
               p[dy][dx] = int'((px >> (4 * ch)) & 12'hF);
            end
         end
         l  = p[0][0] + 2 * p[1][0] + p[2][0];
         r  = p[0][2] + 2 * p[1][2] + p[2][2];
         u  = p[0][0] + 2 * p[0][1] + p[0][2];
         d  = p[2][0] + 2 * p[2][1] + p[2][2];
         gx = (l > r) ? l - r : r - l;
         gy = (u > d) ? u - d : d - u;
         m  = (gx + gy > 15) ? 15 : gx + gy;
         if (md) m = (m >= int'(th)) ? 15 : 0;
         res[4*ch +: 4] = 4'(m);
      end
      return res;
   endfunction

   task automatic send(input logic [11:0] pix, input logic sof, input logic md,
                       input logic [3:0] th, input bit gap);
      exp_t e;
      in_valid = 1'b1;
      in_sof   = sof;
      in_pixel = pix;
      mode     = md;
      thresh   = th;
      if (sof || m_run) begin
         if (sof) m_k = 0;
         img[m_k] = pix;
         e.pix = ref_out(m_k, md, th);
         e.sof = (m_k == W + 1);
         e.cyc = cyc;
         sb.push_back(e);
         m_k++;
         m_run = 1;
         if (m_k == W * H) begin
            m_run = 0;
            m_k   = 0;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic send_frame(input int kind, input logic md, input logic [3:0] th);
      logic [11:0] p;
      base = n_out;
      for (int i = 0; i < W * H; i++) begin
         case (kind)
            0:       p = 12'h777;
            1:       p = 12'(i % W);
            default: p = ((i % W) < 4) ? 12'h000 : 12'hFFF;
         endcase
         send(p, i == 0, md, th, 1'b0);
      end
      drain();
      chk("frame_out_count", 32'(n_out - base), 32'(W * H));
   endtask

   // Scoreboard monitor: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
         end else if (out_valid) begin
            e_mon = sb.pop_front();
            n_out++;
            chk("out_pixel", 32'(out_pixel), 32'(e_mon.pix));
            chk("out_sof", 32'(out_sof), 32'(e_mon.sof));
            chk("latency", cyc, e_mon.cyc + 32'(LATENCY));
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = '0;
      mode     = 1'b0;
      thresh   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_sof", 32'(out_sof), 32'd0);
      chk("reset_out_pixel", 32'(out_pixel), 32'd0);
      rst_n = 1'b1;

      // Partial frame, then reset while outputs are in flight.
      for (int i = 0; i < 20; i++) send(12'($urandom), i == 0, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      m_run = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_out_sof", 32'(out_sof), 32'd0);
      chk("midreset_out_pixel", 32'(out_pixel), 32'd0);
      rst_n = 1'b1;

      // No in_sof since reset: all dropped.
      base = n_out;
      for (int i = 0; i < 10; i++) send(12'h5A5, 1'b0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("idle_drop_count", 32'(n_out - base), 32'd0);

      send_frame(0, MODE_MAG, 4'd0);

      // After a complete frame the block is idle again.
      base = n_out;
      for (int i = 0; i < 5; i++) send(12'h123, 1'b0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("post_frame_drop_count", 32'(n_out - base), 32'd0);

      send_frame(1, MODE_MAG, 4'd0);
      send_frame(1, MODE_THR, 4'd9);
      send_frame(1, MODE_THR, 4'd8);
      send_frame(2, MODE_MAG, 4'd0);

      // Gapped input with a resync part way through a frame.
      base = n_out;
      for (int i = 0; i < 20; i++) send(12'($urandom), i == 0, 1'b0, 4'd0, 1'b1);
      for (int i = 0; i < W * H; i++)
         send(12'($urandom), i == 0, 1'($urandom), 4'($urandom), 1'b1);
      drain();
      chk("gapped_out_count", 32'(n_out - base), 32'(20 + W * H));

      // in_sof coinciding with the last pixel index starts a new frame.
      base = n_out;
      for (int i = 0; i < W * H; i++)
         send(12'($urandom), (i == 0) || (i == W * H - 1), 1'b0, 4'd0, 1'b0);
      for (int i = 1; i < W * H; i++) send(12'($urandom), 1'b0, 1'b0, 4'd0, 1'b0);
      drain();
      chk("last_sof_out_count", 32'(n_out - base), 32'(2 * W * H - 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
